// File: rtl/keypad_code_tx.sv
// Parallel-in, serial-out transmitter for the doorlock keypad code.
// Sends each nibble LSB first and flags NIB_VALID when the lock-side 4-stage register holds it.
module keypad_code_tx #(
    parameter int DIGITS     = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   CODE,
    input  logic                  ABORT,
    output logic                  READY,
    output logic                  BUSY,
    output logic                  Dout,
    output logic                  NIB_VALID,
    output logic [2:0]            NIB_IDX,
    output logic                  DONE
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t      state, state_nxt;
    logic [31:0] shadow, shadow_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [1:0]  bitcnt, bitcnt_nxt;
    logic [2:0]  gcnt, gcnt_nxt;
    logic        busy_nxt, dout_nxt, nv_nxt, done_nxt;
    logic [2:0]  nibidx_nxt;

    logic last_nib, bit_end, gap_end;

    assign last_nib = (idx == 3'(DIGITS - 1));
    assign bit_end  = (bitcnt == 2'd3);
    assign gap_end  = (gcnt == 3'(GAP_CYCLES - 1));
    assign READY    = ~BUSY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            shadow    <= '0;
            idx       <= '0;
            bitcnt    <= '0;
            gcnt      <= '0;
            BUSY      <= 1'b0;
            Dout      <= 1'b0;
            NIB_VALID <= 1'b0;
            NIB_IDX   <= '0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shadow    <= shadow_nxt;
            idx       <= idx_nxt;
            bitcnt    <= bitcnt_nxt;
            gcnt      <= gcnt_nxt;
            BUSY      <= busy_nxt;
            Dout      <= dout_nxt;
            NIB_VALID <= nv_nxt;
            NIB_IDX   <= nibidx_nxt;
            DONE      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ABORT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (START) state_nxt = SHIFT;
                SHIFT: begin
                    if (bit_end) begin
                        if (last_nib)             state_nxt = IDLE;
                        else if (GAP_CYCLES == 0) state_nxt = SHIFT;
                        else                      state_nxt = GAP;
                    end
                end
                GAP:   if (gap_end) state_nxt = SHIFT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Dout is registered, so each branch selects the bit to be on the wire after this edge.
    always_comb begin
        shadow_nxt = shadow;
        idx_nxt    = idx;
        bitcnt_nxt = bitcnt;
        gcnt_nxt   = gcnt;
        busy_nxt   = BUSY;
        dout_nxt   = Dout;
        nv_nxt     = 1'b0;
        done_nxt   = 1'b0;
        nibidx_nxt = NIB_IDX;
        if (ABORT) begin
            busy_nxt = 1'b0;
            dout_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        shadow_nxt               = '0;
                        shadow_nxt[4*DIGITS-1:0] = CODE;
                        idx_nxt                  = '0;
                        bitcnt_nxt               = '0;
                        busy_nxt                 = 1'b1;
                        dout_nxt                 = CODE[0];
                    end
                end
                SHIFT: begin
                    bitcnt_nxt = bitcnt + 2'd1;
                    if (bit_end) begin
                        nv_nxt     = 1'b1;
                        nibidx_nxt = idx;
                        if (last_nib) begin
                            done_nxt = 1'b1;
                            busy_nxt = 1'b0;
                            dout_nxt = 1'b0;
                        end else begin
                            idx_nxt  = idx + 3'd1;
                            gcnt_nxt = '0;
                            if (GAP_CYCLES == 0)
                                dout_nxt = shadow[{idx + 3'd1, 2'b00}];
                            else
                                dout_nxt = 1'b0;
                        end
                    end else begin
                        dout_nxt = shadow[{idx, bitcnt + 2'd1}];
                    end
                end
                GAP: begin
                    if (gap_end) dout_nxt = shadow[{idx, 2'b00}];
                    else         gcnt_nxt = gcnt + 3'd1;
                end
                default: begin
                    busy_nxt = 1'b0;
                    dout_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule
